// File: rtl/div_issue_queue_if.sv
// Handshake bundle between dispatch, the divide issue queue and the divider.
// The master modport is taken by the queue itself; the slave modport is the
// surrounding environment (dispatch on the input side, divider on the output).
interface div_issue_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Input side: valid/pop
  logic             valid;
  logic             pop;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             op_in;

  // Output side: push/ready
  logic             push;
  logic             ready;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             op_out;

  // Status
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  modport master (
    input  valid, a_in, b_in, op_in, ready,
    output pop, push, a_out, b_out, op_out, count, full, empty
  );

  modport slave (
    output valid, a_in, b_in, op_in, ready,
    input  pop, push, a_out, b_out, op_out, count, full, empty
  );
endinterface

// File: rtl/div_issue_queue.sv
// Divide issue queue: a DEPTH-entry FIFO of (a, b, op) divide requests that
// absorbs dispatch bursts while the multi-cycle divider is busy and feeds the
// divider one request at a time.
// Optional build macro: DIV_ISSUE_QUEUE_FULL_POP_EN -- when defined, a full
// queue accepts a new request in the same cycle its head issues.
module div_issue_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  div_issue_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] a_mem_r  [DEPTH];
  logic [WIDTH-1:0] b_mem_r  [DEPTH];
  logic             op_mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             full_s;
  logic             empty_s;
  logic             accept_s;
  logic             issue_s;

  // Occupancy flags, accept/issue decisions; occupancy comes from count_r only.
  always_comb begin
    full_s   = (count_r == CNT_W'(DEPTH));
    empty_s  = (count_r == {CNT_W{1'b0}});
    issue_s  = 1'b0;
    accept_s = 1'b0;
    if (!empty_s) begin
      issue_s = bus.ready;
    end else begin
      issue_s = 1'b0;
    end
`ifdef DIV_ISSUE_QUEUE_FULL_POP_EN
    // A full queue may take a new request when its head leaves this cycle.
    accept_s = bus.valid && (!full_s || issue_s) && !rst;
`else
    accept_s = bus.valid && !full_s && !rst;
`endif
  end

  // Storage, pointers and occupancy counter; reset discards every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_mem_r[i]  <= {WIDTH{1'b0}};
        b_mem_r[i]  <= {WIDTH{1'b0}};
        op_mem_r[i] <= 1'b0;
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        a_mem_r[wr_ptr_r]  <= bus.a_in;
        b_mem_r[wr_ptr_r]  <= bus.b_in;
        op_mem_r[wr_ptr_r] <= bus.op_in;
        wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({accept_s, issue_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head outputs are a combinational view of entry[rd_ptr]; push qualifies them.
  always_comb begin
    bus.pop    = accept_s;
    bus.push   = !empty_s;
    bus.a_out  = a_mem_r[rd_ptr_r];
    bus.b_out  = b_mem_r[rd_ptr_r];
    bus.op_out = op_mem_r[rd_ptr_r];
    bus.count  = count_r;
    bus.full   = full_s;
    bus.empty  = empty_s;
  end
endmodule

// File: tb/tb_div_issue_queue.sv
// Directed self-checking bench for div_issue_queue (WIDTH=32, DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit
// later, well away from the next edge.
module tb_div_issue_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  div_issue_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  div_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.valid = 1'b1; bus.a_in = 32'd99; bus.b_in = 32'd3; bus.op_in = 1'b1;
    bus.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++;
      if (bus.pop !== 1'b0) $display("FAIL reset_pop cyc%0d: got %b want 0", i, bus.pop);
      else pass_cnt++;
      step();
    end
    rst = 1'b0; bus.valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.push !== 1'b0) $display("FAIL reset_push: got %b want 0", bus.push); else pass_cnt++;
    total_cnt++;
    if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty); else pass_cnt++;
    total_cnt++;
    if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else pass_cnt++;
    total_cnt++;
    if (bus.count !== 3'd0) $display("FAIL reset_count: got %0d want 0", bus.count); else pass_cnt++;
    total_cnt++;
    if (bus.a_out !== 32'd0) $display("FAIL reset_a_out: got %0d want 0", bus.a_out); else pass_cnt++;
    step();
  endtask

  task automatic test_single();
    bus.valid = 1'b1; bus.a_in = 32'd100; bus.b_in = 32'd7; bus.op_in = 1'b1;
    bus.ready = 1'b0;
    #1;
    total_cnt++;
    if (bus.pop !== 1'b1) $display("FAIL single_pop: got %b want 1", bus.pop); else pass_cnt++;
    total_cnt++;
    if (bus.push !== 1'b0) $display("FAIL single_no_flow: got %b want 0", bus.push); else pass_cnt++;
    step();
    bus.valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.push !== 1'b1) $display("FAIL single_push: got %b want 1", bus.push); else pass_cnt++;
    total_cnt++;
    if (bus.a_out !== 32'd100) $display("FAIL single_a_out: got %0d want 100", bus.a_out); else pass_cnt++;
    total_cnt++;
    if (bus.b_out !== 32'd7) $display("FAIL single_b_out: got %0d want 7", bus.b_out); else pass_cnt++;
    total_cnt++;
    if (bus.op_out !== 1'b1) $display("FAIL single_op_out: got %b want 1", bus.op_out); else pass_cnt++;
    total_cnt++;
    if (bus.count !== 3'd1) $display("FAIL single_count: got %0d want 1", bus.count); else pass_cnt++;
    bus.ready = 1'b1;
    step();
    bus.ready = 1'b0;
    #1;
    total_cnt++;
    if (bus.push !== 1'b0) $display("FAIL single_drained: got %b want 0", bus.push); else pass_cnt++;
    total_cnt++;
    if (bus.count !== 3'd0) $display("FAIL single_count0: got %0d want 0", bus.count); else pass_cnt++;
    step();
  endtask

  task automatic test_fill();
    bus.ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.valid = 1'b1; bus.a_in = 32'(i); bus.b_in = 32'(i + 100); bus.op_in = 1'b0;
      #1;
      total_cnt++;
      if (bus.pop !== 1'b1) $display("FAIL fill_pop a=%0d: got %b want 1", i, bus.pop); else pass_cnt++;
      step();
    end
    bus.valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.count !== 3'd4) $display("FAIL fill_count: got %0d want 4", bus.count); else pass_cnt++;
    total_cnt++;
    if (bus.full !== 1'b1) $display("FAIL fill_full: got %b want 1", bus.full); else pass_cnt++;
    total_cnt++;
    if (bus.a_out !== 32'd1) $display("FAIL fill_head: got %0d want 1", bus.a_out); else pass_cnt++;
    bus.valid = 1'b1; bus.a_in = 32'd5; bus.b_in = 32'd105;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (bus.pop !== 1'b0) $display("FAIL full_stall cyc%0d: got %b want 0", i, bus.pop); else pass_cnt++;
      step();
    end
    bus.ready = 1'b1;
    #1;
`ifdef DIV_ISSUE_QUEUE_FULL_POP_EN
    total_cnt++;
    if (bus.pop !== 1'b1) $display("FAIL full_pop_same: got %b want 1", bus.pop); else pass_cnt++;
    step();
    bus.ready = 1'b0; bus.valid = 1'b0;
    #1;
`else
    total_cnt++;
    if (bus.pop !== 1'b0) $display("FAIL full_pop_same: got %b want 0", bus.pop); else pass_cnt++;
    step();
    bus.ready = 1'b0;
    #1;
    total_cnt++;
    if (bus.count !== 3'd3) $display("FAIL full_after_issue: got %0d want 3", bus.count); else pass_cnt++;
    total_cnt++;
    if (bus.pop !== 1'b1) $display("FAIL full_pop_next: got %b want 1", bus.pop); else pass_cnt++;
    step();
    bus.valid = 1'b0;
    #1;
`endif
    total_cnt++;
    if (bus.count !== 3'd4) $display("FAIL full_refill_count: got %0d want 4", bus.count); else pass_cnt++;
    bus.ready = 1'b1;
    for (int e = 2; e <= 5; e++) begin
      #1;
      total_cnt++;
      if (bus.push !== 1'b1 || bus.a_out !== 32'(e) || bus.b_out !== 32'(e + 100))
        $display("FAIL fill_drain: got push=%b a=%0d b=%0d want push=1 a=%0d b=%0d",
                 bus.push, bus.a_out, bus.b_out, e, e + 100);
      else pass_cnt++;
      step();
    end
    bus.ready = 1'b0;
    #1;
    total_cnt++;
    if (bus.empty !== 1'b1) $display("FAIL fill_empty: got %b want 1", bus.empty); else pass_cnt++;
    step();
  endtask

  task automatic test_stream();
    int model[$];
    int next_in;
    int next_out;
    int cyc;
    bit exp_pop;
    bit do_issue;
    next_in = 0; next_out = 0; cyc = 0;
    while (next_out < 10 && cyc < 100) begin
      bus.valid = (next_in < 10);
      bus.a_in  = 32'(next_in);
      bus.b_in  = 32'(next_in * 3);
      bus.op_in = next_in[0];
      bus.ready = ((cyc % 2) == 0);
      #1;
      do_issue = (model.size() != 0) && bus.ready;
`ifdef DIV_ISSUE_QUEUE_FULL_POP_EN
      exp_pop = bus.valid && (model.size() < DEPTH || do_issue);
`else
      exp_pop = bus.valid && (model.size() < DEPTH);
`endif
      total_cnt++;
      if (bus.pop !== exp_pop) $display("FAIL stream_pop cyc%0d: got %b want %b", cyc, bus.pop, exp_pop);
      else pass_cnt++;
      total_cnt++;
      if (bus.count !== 3'(model.size()) || bus.count > 3'd4)
        $display("FAIL stream_count cyc%0d: got %0d want %0d", cyc, bus.count, model.size());
      else pass_cnt++;
      if (do_issue) begin
        total_cnt++;
        if (bus.a_out !== 32'(model[0]) || bus.b_out !== 32'(model[0] * 3))
          $display("FAIL stream_order: got a=%0d b=%0d want a=%0d b=%0d",
                   bus.a_out, bus.b_out, model[0], model[0] * 3);
        else pass_cnt++;
        void'(model.pop_front());
        next_out++;
      end
      if (exp_pop) begin
        model.push_back(next_in);
        next_in++;
      end
      step();
      cyc++;
    end
    bus.valid = 1'b0; bus.ready = 1'b0;
    total_cnt++;
    if (next_out != 10) $display("FAIL stream_timeout: got %0d issued want 10", next_out);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (bus.empty !== 1'b1) $display("FAIL stream_empty: got %b want 1", bus.empty); else pass_cnt++;
    step();
  endtask

  task automatic test_simul();
    bus.valid = 1'b1; bus.a_in = 32'd11; bus.b_in = 32'd0; bus.op_in = 1'b0;
    bus.ready = 1'b0;
    step();
    bus.a_in = 32'd22; bus.b_in = 32'd2; bus.ready = 1'b1;
    #1;
    total_cnt++;
    if (bus.pop !== 1'b1 || bus.push !== 1'b1 || bus.a_out !== 32'd11)
      $display("FAIL simul_pre: got pop=%b push=%b a=%0d want pop=1 push=1 a=11",
               bus.pop, bus.push, bus.a_out);
    else pass_cnt++;
    step();
    bus.valid = 1'b0; bus.ready = 1'b0;
    #1;
    total_cnt++;
    if (bus.push !== 1'b1) $display("FAIL simul_push: got %b want 1", bus.push); else pass_cnt++;
    total_cnt++;
    if (bus.a_out !== 32'd22) $display("FAIL simul_head: got %0d want 22", bus.a_out); else pass_cnt++;
    total_cnt++;
    if (bus.count !== 3'd1) $display("FAIL simul_count: got %0d want 1", bus.count); else pass_cnt++;
    bus.ready = 1'b1;
    step();
    bus.ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.valid = 1'b1; bus.a_in = 32'(40 + i); bus.b_in = 32'd1; bus.op_in = 1'b1;
      step();
    end
    bus.valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.count !== 3'd3) $display("FAIL mid_count3: got %0d want 3", bus.count); else pass_cnt++;
    rst = 1'b1; bus.valid = 1'b1; bus.a_in = 32'd50;
    #1;
    total_cnt++;
    if (bus.pop !== 1'b0) $display("FAIL mid_rst_pop: got %b want 0", bus.pop); else pass_cnt++;
    step();
    rst = 1'b0; bus.valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.count !== 3'd0 || bus.push !== 1'b0)
      $display("FAIL mid_rst_state: got count=%0d push=%b want count=0 push=0", bus.count, bus.push);
    else pass_cnt++;
    total_cnt++;
    if (bus.a_out !== 32'd0) $display("FAIL mid_rst_clear: got %0d want 0", bus.a_out); else pass_cnt++;
    bus.valid = 1'b1; bus.a_in = 32'd33; bus.b_in = 32'd0; bus.op_in = 1'b0;
    step();
    bus.valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.push !== 1'b1 || bus.a_out !== 32'd33 || bus.count !== 3'd1)
      $display("FAIL mid_next_head: got push=%b a=%0d count=%0d want push=1 a=33 count=1",
               bus.push, bus.a_out, bus.count);
    else pass_cnt++;
    step();
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_simul();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/div_issue_queue.md
Name: div_issue_queue

Overview:
- Parameterised FIFO that buffers divide requests (a, b, op) and issues them one at a time into the divider's valid/pop handshake.
- Sits directly upstream of the divider. Absorbs bursts from the dispatch stage while the multi-cycle divider is busy.
- Uses the codebase's unit handshake on both sides: valid/pop on the input, push/ready on the output.

Parameters:
- WIDTH, 32, operand width in bits.
- DEPTH, 4, number of entries; must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- valid  input  1  upstream request present on a_in/b_in/op_in.
- pop  output  1  request accepted this cycle; combinational.
- a_in  input  WIDTH  dividend.
- b_in  input  WIDTH  divisor.
- op_in  input  1  divide operation select; passed through unchanged.
- push  output  1  head entry valid; drives the divider's valid.
- ready  input  1  divider takes the head this cycle; driven from the divider's pop.
- a_out  output  WIDTH  head dividend.
- b_out  output  WIDTH  head divisor.
- op_out  output  1  head op.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst high at a clock edge): rd_ptr=0, wr_ptr=0, count=0, all storage entries cleared to 0.
  - After reset: push=0, empty=1, full=0, a_out/b_out/op_out=0.
- pop is forced 0 while rst is high.
- Reset mid-operation discards all entries. Any request presented during the reset cycle is not accepted.
- Accept rule: pop = valid && !full && !rst. On pop, write a_in/b_in/op_in at wr_ptr; wr_ptr increments modulo DEPTH.
- Issue rule: push = !empty, a registered-state function. a_out/b_out/op_out reflect entry[rd_ptr] combinationally.
  - On push && ready, rd_ptr increments modulo DEPTH at the edge.
  - ready while push=0 is ignored.
- Count update at the edge:
  - +1 on accept only.
  - -1 on issue only.
  - unchanged on simultaneous accept and issue.
  - unchanged when neither occurs.
- Simultaneous accept and issue at count=1: the head is issued and the new entry becomes the head next cycle. push stays 1 and there is no bubble.
- Full: pop=0 while valid is held. Upstream must hold a_in/b_in/op_in stable until pop=1.
- Empty: push=0. Head outputs show stale storage contents; consumers must qualify them with push.
- Latency: an entry written at edge N is visible on push/head at cycle N+1 when the queue was empty. There is no same-cycle flow-through.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. Occupancy comes from the separate count register, not from pointer compare.
- Ordering is strict FIFO.
- Operands are not inspected or modified. A zero divisor is queued like any other value.

Optional Feature:
- Macro: DIV_ISSUE_QUEUE_FULL_POP_EN.
- Defined: pop = valid && (!full || (push && ready)) && !rst.
  - A full queue accepts a new request in the same cycle the head issues.
  - count stays DEPTH.
  - wr_ptr and rd_ptr both advance.
- Not defined: pop = valid && !full && !rst, and a full queue stalls one cycle even when the head issues.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with valid=1 → pop=0 throughout; after reset push=0, empty=1, count=0, a_out=0.
- Single request: write a=100, b=7, op=1 with ready=0 → pop=1 that cycle; next cycle push=1, a_out=100, b_out=7, op_out=1, count=1. Pulse ready → push=0 next cycle.
- Fill to full (DEPTH=4): write a=1..4 with ready=0 → count=4, full=1. Fifth request a=5 gives pop=0, held for 3 cycles. Then ready=1 for one cycle → a=5 is accepted the following cycle.
  - With DIV_ISSUE_QUEUE_FULL_POP_EN defined: a=5 is accepted in the same cycle as the issue, and count stays 4.
- Streaming order: 10 requests a=0..9 with ready toggling 1,0,1,... → outputs issue in order 0..9, none dropped or duplicated, count never exceeds 4. This also exercises pointer wrap past DEPTH.
- Simultaneous at count=1: head a=11 with ready=1 and valid=1 a=22 in the same cycle → next cycle push=1, a_out=22, count=1.
- Reset mid-operation: count=3, assert rst → next cycle count=0, push=0. The next request a=33 issues as the head.
